// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared types, constants and field helpers for the sequential FP32 adder
package fp_add_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } fp_unpacked_t;

    // Denormals are reported as zero; the hidden one is always inserted.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.mant    = {1'b1, x[22:0]};
        u.is_zero = (x[30:23] == 8'd0);
        u.is_inf  = (x[30:23] == 8'(EXP_MAX)) && (x[22:0] == 23'd0);
        u.is_nan  = (x[30:23] == 8'(EXP_MAX)) && (x[22:0] != 23'd0);
        return u;
    endfunction

    function automatic logic [31:0] fp_pack(input logic sign, input logic signed [9:0] e,
                                            input logic [FRAC_W-1:0] frac);
        if (e >= 10'sd255) begin
            return {sign, 8'hFF, 23'd0};
        end
        if (e <= 10'sd0) begin
            return {sign, 31'd0};
        end
        return {sign, e[7:0], frac};
    endfunction

endpackage

// File: rtl/add25bit.sv
// rtl/add25bit.sv - 25-bit ripple-carry adder shared by the add/sub step
module add25bit (
    input  logic [24:0] a,
    input  logic [24:0] b,
    input  logic        cin,
    output logic [24:0] sum
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < 25; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/fp_add_seq.sv
// rtl/fp_add_seq.sv - multi-cycle FP32 add/sub sequencer around one shared mantissa adder
module fp_add_seq
    import fp_add_pkg::*;
#(
    parameter int          MAX_ALIGN = 25,
    parameter logic [31:0] QNAN      = QNAN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int CNT_W = $clog2(MAX_ALIGN + 1);

    state_t state_q, state_d;

    fp_unpacked_t      ua, ub;
    logic [31:0]       b_eff;
    logic              swap;
    logic              sign_big;
    logic [EXP_W-1:0]  exp_big, exp_small, exp_diff;
    logic [MANT_W-1:0] mant_big, mant_small;
    logic [CNT_W-1:0]  cnt_init;
    logic              special;
    logic [31:0]       special_val;

    logic              sign_q;
    logic              eff_sub_q;
    logic [MANT_W-1:0] ma_q, mb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [MANT_W:0]   m_q;
    logic signed [9:0] e_q;
    logic              out_valid_q;
    logic [31:0]       out_data_q;

    logic [MANT_W:0]   add_a, add_b, add_sum;
    logic [MANT_W:0]   norm_m;
    logic signed [9:0] norm_e;
    logic              norm_done;
    logic [31:0]       norm_data;

    // Operand unpack, magnitude ordering and special-case detection at accept.
    always_comb begin
        b_eff      = {in_b[31] ^ in_sub, in_b[30:0]};
        ua         = fp_unpack(in_a);
        ub         = fp_unpack(b_eff);
        swap       = b_eff[30:0] > in_a[30:0];
        sign_big   = swap ? ub.sign : ua.sign;
        exp_big    = swap ? ub.exp  : ua.exp;
        exp_small  = swap ? ua.exp  : ub.exp;
        mant_big   = swap ? ub.mant : ua.mant;
        mant_small = swap ? ua.mant : ub.mant;
        exp_diff   = exp_big - exp_small;
        cnt_init   = (exp_diff > EXP_W'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN) : CNT_W'(exp_diff);

        special     = 1'b1;
        special_val = '0;
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
            special_val = QNAN;
        end else if (ua.is_inf) begin
            special_val = in_a;
        end else if (ub.is_inf) begin
            special_val = b_eff;
        end else if (ua.is_zero && ub.is_zero) begin
            special_val = {ua.sign & ub.sign, 31'd0};
        end else if (ua.is_zero) begin
            special_val = b_eff;
        end else if (ub.is_zero) begin
            special_val = in_a;
        end else begin
            special = 1'b0;
        end
    end

    // Subtraction is two's complement through the same adder; ma >= mb so no borrow out.
    assign add_a = {1'b0, ma_q};
    assign add_b = eff_sub_q ? ~{1'b0, mb_q} : {1'b0, mb_q};

    add25bit u_add (
        .a   (add_a),
        .b   (add_b),
        .cin (eff_sub_q),
        .sum (add_sum)
    );

    always_comb begin
        norm_m    = m_q;
        norm_e    = e_q;
        norm_done = 1'b0;
        if (m_q == '0) begin
            norm_done = 1'b1;
        end else if (m_q[MANT_W]) begin
            norm_m    = m_q >> 1;
            norm_e    = e_q + 10'sd1;
            norm_done = 1'b1;
        end else if (!m_q[MANT_W-1]) begin
            norm_m = m_q << 1;
            norm_e = e_q - 10'sd1;
        end else begin
            norm_done = 1'b1;
        end
        norm_data = (m_q == '0) ? 32'd0 : fp_pack(sign_q, norm_e, norm_m[FRAC_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (special) begin
                        state_d = DONE;
                    end else if (cnt_init == '0) begin
                        state_d = ADD;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ADD;
                end
            end
            ADD: state_d = NORM;
            NORM: begin
                if (norm_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            ma_q        <= '0;
            mb_q        <= '0;
            cnt_q       <= '0;
            m_q         <= '0;
            e_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q    <= sign_big;
                        eff_sub_q <= ua.sign ^ ub.sign;
                        ma_q      <= mant_big;
                        mb_q      <= mant_small;
                        cnt_q     <= cnt_init;
                        e_q       <= $signed({2'b00, exp_big});
                        if (special) begin
                            out_data_q  <= special_val;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ALIGN: begin
                    mb_q  <= mb_q >> 1;
                    cnt_q <= cnt_q - 1'b1;
                end
                ADD: begin
                    m_q <= add_sum;
                end
                NORM: begin
                    m_q <= norm_m;
                    e_q <= norm_e;
                    if (norm_done) begin
                        out_data_q  <= norm_data;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// tb/tb_fp_add_seq.sv - self-checking bench for fp_add_seq against an arithmetic reference model
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    fp_add_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Value-level model: align by exponent difference, integer add, renormalise, pack.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  output logic [31:0] r, output int lat);
        logic [31:0] bb, big, sml;
        int          ea, eb, d, e, nc;
        longint      mbig, msml, s;
        bit          a_nan, b_nan, a_inf, b_inf, a_z, b_z;
        bb    = {b[31] ^ sub, b[30:0]};
        ea    = int'(a[30:23]);
        eb    = int'(bb[30:23]);
        a_nan = (ea == 255) && (a[22:0] != 0);
        b_nan = (eb == 255) && (bb[22:0] != 0);
        a_inf = (ea == 255) && (a[22:0] == 0);
        b_inf = (eb == 255) && (bb[22:0] == 0);
        a_z   = (ea == 0);
        b_z   = (eb == 0);
        lat   = 1;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != bb[31]))) r = 32'h7FC0_0000;
        else if (a_inf)       r = a;
        else if (b_inf)       r = bb;
        else if (a_z && b_z)  r = {a[31] & bb[31], 31'd0};
        else if (a_z)         r = bb;
        else if (b_z)         r = a;
        else begin
            if (bb[30:0] > a[30:0]) begin big = bb; sml = a;  end
            else                    begin big = a;  sml = bb; end
            mbig = longint'({1'b1, big[22:0]});
            msml = longint'({1'b1, sml[22:0]});
            d = int'(big[30:23]) - int'(sml[30:23]);
            if (d > 25) d = 25;
            msml = msml >> d;
            s  = (big[31] == sml[31]) ? mbig + msml : mbig - msml;
            e  = int'(big[30:23]);
            nc = 1;
            if (s == 0) begin
                r = 32'd0;
            end else begin
                if (s >= (longint'(1) << 24)) begin
                    s = s >> 1;
                    e = e + 1;
                end else begin
                    while (s < (longint'(1) << 23)) begin
                        s  = s << 1;
                        e  = e - 1;
                        nc = nc + 1;
                    end
                end
                if (e >= 255)     r = {big[31], 8'hFF, 23'd0};
                else if (e <= 0)  r = {big[31], 31'd0};
                else              r = {big[31], 8'(e), 23'(s)};
            end
            lat = 1 + d + 1 + nc;
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input string tag, output logic [31:0] got, output int got_lat);
        logic [31:0] exp_r;
        int          exp_lat;
        model(a, b, sub, exp_r, exp_lat);
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        got_lat  = 1;
        while (!out_valid && got_lat < 100) begin
            @(negedge clk);
            got_lat++;
        end
        got = out_data;
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".data"}, got, exp_r);
        chk({tag, ".latency"}, got_lat, exp_lat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".idle_after"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic [31:0] got, ra, rb, held;
        int          lat, mode, ea, eb, seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.out_data", out_data, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);

        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, "one_plus_one", got, lat);
        chk("one_plus_one.const", got, 32'h4000_0000);
        chk("one_plus_one.lat_const", lat, 32'd3);

        run_op(32'h3F80_0000, 32'h3F40_0000, 1'b1, "one_minus_075", got, lat);
        chk("one_minus_075.const", got, 32'h3E80_0000);
        chk("one_minus_075.lat_const", lat, 32'd6);

        run_op(32'h3FC0_0000, 32'hBFC0_0000, 1'b0, "cancel", got, lat);
        chk("cancel.const", got, 32'h0000_0000);

        run_op(32'h3F80_0000, 32'h3080_0000, 1'b0, "align_cap", got, lat);
        chk("align_cap.const", got, 32'h3F80_0000);
        chk("align_cap.lat_const", lat, 32'd28);

        run_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, "inf_minus_inf", got, lat);
        chk("inf_minus_inf.const", got, 32'h7FC0_0000);
        chk("inf_minus_inf.lat_const", lat, 32'd1);

        run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, "overflow", got, lat);
        chk("overflow.const", got, 32'h7F80_0000);

        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, "neg_zeros", got, lat);
        chk("neg_zeros.const", got, 32'h8000_0000);

        run_op(32'h4040_0000, 32'h0000_0000, 1'b1, "zero_b_sub", got, lat);
        chk("zero_b_sub.const", got, 32'h4040_0000);

        // Backpressure: result must hold while out_ready is low and new requests are ignored.
        @(negedge clk);
        in_a     = 32'h3F80_0000;
        in_b     = 32'h3F80_0000;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
        held = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_a     = 32'h4100_0000;
                in_b     = 32'h4100_0000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("bp.hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp.hold_data", out_data, held);
            chk("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp.release_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("bp.pulse_ignored", {30'd0, busy, out_valid}, 32'd0);

        // Reset during alignment aborts the operation silently.
        in_a     = 32'h4B00_0000;
        in_b     = 32'h3F80_0000;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_align.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_align.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_align.busy", {31'd0, busy}, 32'd0);
        chk("rst_align.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_align.out_data", out_data, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_align.no_result", seen, 32'd0);

        // Randomised operands: mixed exponent gaps, near-cancellation, tiny and special values.
        for (int n = 0; n < 160; n++) begin
            mode = $urandom_range(0, 9);
            ea   = (mode < 2) ? $urandom_range(1, 8) : $urandom_range(1, 254);
            eb   = ea - $urandom_range(0, 30);
            if (eb < 1) eb = 1;
            ra = {1'($urandom), 8'(ea), 23'($urandom)};
            rb = {1'($urandom), 8'(eb), 23'($urandom)};
            if (mode == 3) rb = {~ra[31], ra[30:4], 4'($urandom)};
            if (mode == 9) rb = {1'($urandom), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                                 ($urandom_range(0, 1) != 0) ? 23'($urandom) : 23'd0};
            if ($urandom_range(0, 1) != 0) begin
                held = ra;
                ra   = rb;
                rb   = held;
            end
            run_op(ra, rb, 1'($urandom), "rand", got, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
